// File: rtl/da_lut_loader.sv
// da_lut_loader: collects 64 signed taps, then streams the 8-bank
// distributed-arithmetic partial-sum table to the ROM write port.
module da_lut_loader #(
    parameter int COEF_W = 16,
    parameter int NTAP   = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic                     coef_valid,
    output logic                     coef_ready,
    input  logic                     coef_clr,
    input  logic                     start,
    output logic        [19:0]       CIN,
    output logic        [10:0]       CADDR,
    output logic                     CLOAD,
    input  logic                     wr_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int            TW   = $clog2(NTAP);
    localparam logic [TW-1:0] LAST = TW'(NTAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FULL,
        S_GEN,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [COEF_W-1:0]  r_coef [NTAP];
    logic        [TW-1:0]      r_tap_cnt;
    logic        [10:0]        r_idx;
    logic                      r_cload;
    logic signed [19:0]        r_cin;

    logic                      w_accept;
    logic                      w_launch;
    logic                      w_xfer;
    logic                      w_last;
    logic        [10:0]        w_nidx;
    logic signed [19:0]        w_entry;

    assign w_accept = (r_state == S_IDLE) && coef_valid && !coef_clr;
    assign w_launch = (r_state == S_FULL) && start && !coef_clr;
    assign w_xfer   = (r_state == S_GEN) && r_cload && wr_ready;
    assign w_last   = (r_idx == 11'h7FF);

    // The entry register always holds the next index to be offered.
    assign w_nidx = (r_state == S_GEN) ? r_idx + 11'd1 : 11'd0;

    always_comb begin
        w_entry = '0;
        for (int k = 0; k < 8; k++) begin
            if (w_nidx[k]) begin
                w_entry = w_entry + 20'(r_coef[{w_nidx[10:8], 3'(k)}]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && r_tap_cnt == LAST) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (coef_clr) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_FULL;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NTAP; i++) begin
                r_coef[i] <= '0;
            end
        end else if (w_accept) begin
            r_coef[r_tap_cnt] <= coef_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tap_cnt <= '0;
            r_idx     <= '0;
            r_cload   <= 1'b0;
            r_cin     <= '0;
        end else begin
            if (coef_clr && (r_state == S_IDLE || r_state == S_FULL)) begin
                r_tap_cnt <= '0;
            end else if (w_accept) begin
                r_tap_cnt <= r_tap_cnt + TW'(1);
            end

            if (w_launch) begin
                r_idx   <= 11'd0;
                r_cload <= 1'b1;
                r_cin   <= w_entry;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_cload <= 1'b0;
                end else begin
                    r_idx <= w_nidx;
                    r_cin <= w_entry;
                end
            end
        end
    end

    assign CIN        = r_cin;
    assign CADDR      = r_idx;
    assign CLOAD      = r_cload;
    assign coef_ready = (r_state == S_IDLE);
    assign busy       = (r_state == S_GEN);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_da_lut_loader.sv
// Randomized scoreboard bench for da_lut_loader: the table is predicted
// from a plain-integer model of the loaded coefficients.
module tb_da_lut_loader;

    logic               clk;
    logic               resetn;
    logic signed [15:0] coef_in;
    logic               coef_valid;
    logic               coef_ready;
    logic               coef_clr;
    logic               start;
    logic        [19:0] CIN;
    logic        [10:0] CADDR;
    logic               CLOAD;
    logic               wr_ready;
    logic               busy;
    logic               done;

    da_lut_loader #(.COEF_W(16), .NTAP(64)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_clr   (coef_clr),
        .start      (start),
        .CIN        (CIN),
        .CADDR      (CADDR),
        .CLOAD      (CLOAD),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [10:0] a;
        logic [19:0] d;
    } exp_t;

    exp_t q[$];
    int   m_coef [64];
    int   m_cnt;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   done_base;
    int   stalls;
    bit   done_pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Table entry: for bank b, sum of coefficients 8b+k whose address bit k is set.
    function automatic logic [19:0] exp_entry(input int addr);
        int b;
        int a;
        int s;
        b = addr / 256;
        a = addr % 256;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            if (((a >> k) & 1) == 1) s += m_coef[8 * b + k];
        end
        return 20'(s);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 64; i++) m_coef[i] = 0;
        m_cnt = 0;
        q.delete();
        done_pending = 0;
        stalls = 0;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_reset();
        chk("rst_CLOAD", CLOAD, 0);
        chk("rst_CIN", CIN, 0);
        chk("rst_CADDR", CADDR, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_coef_ready", coef_ready, 1);
    endtask

    function automatic int coef_val(input int mode, input int k);
        case (mode)
            0:       return 1;
            1:       return -32768;
            2:       return k;
            default: return int'($urandom_range(65535)) - 32768;
        endcase
    endfunction

    task automatic load(input int n, input int mode);
        int v;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                coef_valid = 1'b0;
                tick();
            end
            v = coef_val(mode, m_cnt);
            coef_in = 16'(v);
            coef_valid = 1'b1;
            chk("load_coef_ready", coef_ready, 1);
            tick();
            m_coef[m_cnt] = v;
            m_cnt++;
        end
        coef_valid = 1'b0;
        if (m_cnt == 64) chk("full_coef_ready", coef_ready, 0);
    endtask

    task automatic clr(input bit with_start);
        coef_clr = 1'b1;
        start = with_start;
        coef_valid = with_start;
        tick();
        coef_clr = 1'b0;
        start = 1'b0;
        coef_valid = 1'b0;
        m_cnt = 0;
        chk("clr_coef_ready", coef_ready, 1);
        chk("clr_busy", busy, 0);
    endtask

    function automatic logic wr_pat(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return (n % 4 == 0) || (n % 4 == 3);
            default: return 1'($urandom_range(1));
        endcase
    endfunction

    task automatic push_table;
        exp_t e;
        for (int a = 0; a < 2048; a++) begin
            e.a = 11'(a);
            e.d = exp_entry(a);
            q.push_back(e);
        end
    endtask

    task automatic gen(input int mode);
        int n;
        push_table();
        stalls = 0;
        done_base = cyc;
        done_pending = 1;
        start = 1'b1;
        wr_ready = wr_pat(mode, 0);
        tick();
        start = 1'b0;
        n = 0;
        while (done_pending && n < 12000) begin
            wr_ready = wr_pat(mode, n);
            n++;
            tick();
        end
        if (done_pending) begin
            n_checks++;
            n_errors++;
            $display("FAIL gen_timeout: no done after %0d cycles", n);
            done_pending = 0;
            q.delete();
        end
        wr_ready = 1'b0;
        chk("post_done_low", done, 0);
        chk("post_busy", busy, 0);
        chk("post_CLOAD", CLOAD, 0);
        chk("post_coef_ready", coef_ready, 0);
    endtask

    task automatic gen_abort;
        push_table();
        stalls = 0;
        done_base = cyc;
        done_pending = 1;
        start = 1'b1;
        wr_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (500) tick();
        chk("abort_CADDR", CADDR, 500);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_reset();
        chk("abort_CLOAD", CLOAD, 0);
        chk("abort_busy", busy, 0);
        chk("abort_coef_ready", coef_ready, 1);
        wr_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (CLOAD) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: CADDR %0h CIN %0h with none pending",
                             CADDR, CIN);
                end else begin
                    chk("CADDR", 32'(CADDR), 32'(q[0].a));
                    chk("CIN", 32'(CIN), 32'(q[0].d));
                    chk("gen_busy", busy, 1);
                    if (wr_ready) void'(q.pop_front());
                    else stalls++;
                end
            end
            if (done) begin
                if (!done_pending) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_done: done=1 at cycle %0d", cyc);
                end else begin
                    chk("done_cycle", cyc, done_base + 2049 + stalls);
                    chk("queue_drained", q.size(), 0);
                    done_pending = 0;
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b0;
        coef_in = '0;
        coef_valid = 1'b0;
        coef_clr = 1'b0;
        start = 1'b0;
        wr_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        do_reset();

        load(64, 0);
        gen(0);
        gen(1);

        clr(0);
        load(64, 1);
        gen(0);

        clr(0);
        load(64, 2);
        gen(2);

        do_reset();
        load(10, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) begin
            chk("partial_CLOAD", CLOAD, 0);
            chk("partial_busy", busy, 0);
            chk("partial_coef_ready", coef_ready, 1);
            tick();
        end
        load(54, 3);
        coef_in = 16'sh1234;
        coef_valid = 1'b1;
        repeat (3) begin
            chk("no_65th_ready", coef_ready, 0);
            tick();
        end
        coef_valid = 1'b0;
        gen(2);

        clr(1);
        repeat (3) begin
            chk("clr_start_CLOAD", CLOAD, 0);
            tick();
        end
        load(64, 3);
        gen(2);

        gen_abort();
        load(64, 3);
        gen(0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
